// File: rtl/mem_bank_arb.sv
// Multi-port arbiter in front of word-interleaved SRAM banks. Port 0 wins any
// bank it targets; ports 1.. share each bank round-robin; reads return after RD_LAT.

module mem_bank_arb_bank #(
  parameter int NUM_PORTS  = 4,
  parameter int BANK_DEPTH = 1024,
  parameter int PW         = 2,
  parameter int RW         = 10
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic [NUM_PORTS-1:0]         hit,
  input  logic [NUM_PORTS-1:0]         we,
  input  logic [NUM_PORTS-1:0][RW-1:0] row,
  input  logic [NUM_PORTS-1:0][3:0]    wstrb,
  input  logic [NUM_PORTS-1:0][31:0]   wdata,
  output logic [NUM_PORTS-1:0]         gnt,
  output logic [31:0]                  rdata
);
  logic [31:0]   mem [BANK_DEPTH];
  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] win;
  logic          any;
  int            p;

  // rr_ptr names the requester searched first among ports 1..NUM_PORTS-1
  always_comb begin
    win = '0;
    any = hit[0];
    p   = 0;
    if (!hit[0]) begin
      for (int k = 0; k < NUM_PORTS-1; k++) begin
        p = 1 + ((int'(rr_ptr) - 1 + k) % (NUM_PORTS-1));
        if (!any && hit[PW'(p)]) begin
          any = 1'b1;
          win = PW'(p);
        end
      end
    end
    gnt = '0;
    if (any) gnt[win] = 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n)
      rr_ptr <= PW'(1);
    else if (any && win != '0)
      rr_ptr <= (win == PW'(NUM_PORTS-1)) ? PW'(1) : win + PW'(1);
  end

  // hit is already gated by reset, so no grant means no write
  always_ff @(posedge i_clk) begin
    if (any && we[win]) begin
      for (int i = 0; i < 4; i++)
        if (wstrb[win][i]) mem[row[win]][8*i +: 8] <= wdata[win][8*i +: 8];
    end
    if (any && !we[win]) rdata <= mem[row[win]];
  end
endmodule

module mem_bank_arb #(
  parameter int NUM_PORTS  = 4,
  parameter int NUM_BANKS  = 8,
  parameter int BANK_DEPTH = 1024,
  parameter int RD_LAT     = 2
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_flush,
  input  logic [NUM_PORTS-1:0]     i_req,
  input  logic [NUM_PORTS-1:0]     i_we,
  input  logic [NUM_PORTS*32-1:0]  i_addr,
  input  logic [NUM_PORTS*4-1:0]   i_wstrb,
  input  logic [NUM_PORTS*32-1:0]  i_wdata,
  output logic [NUM_PORTS-1:0]     o_gnt,
  output logic [NUM_PORTS-1:0]     o_rvalid,
  output logic [NUM_PORTS*32-1:0]  o_rdata,
  output logic [31:0]              o_conflict_cnt
);
  localparam int BW = $clog2(NUM_BANKS);
  localparam int RW = $clog2(BANK_DEPTH);
  localparam int PW = $clog2(NUM_PORTS);
  localparam int CW = PW + 1;

  logic [NUM_PORTS-1:0][31:0]          addr_a, wdata_a, rdata_a;
  logic [NUM_PORTS-1:0][3:0]           wstrb_a;
  logic [NUM_PORTS-1:0][BW-1:0]        bank_sel, bsel_q;
  logic [NUM_PORTS-1:0][RW-1:0]        row_sel;
  logic [NUM_BANKS-1:0][NUM_PORTS-1:0] bank_hit, bank_gnt;
  logic [NUM_PORTS-1:0][NUM_BANKS-1:0] gnt_t;
  logic [NUM_BANKS-1:0][31:0]          bank_rdata;
  logic [NUM_PORTS-1:0][31:0]          d1, d2_q, d_out;
  logic [2:1][NUM_PORTS-1:0]           vld_pipe;
  logic [NUM_PORTS-1:0]                vld_in;
  logic [CW-1:0]                       denied;
  logic [32:0]                         cnt_sum;
  logic [31:0]                         cnt_q;
  logic                                unused_addr;

  assign addr_a  = i_addr;
  assign wdata_a = i_wdata;
  assign wstrb_a = i_wstrb;
  assign o_rdata = rdata_a;
  // byte offset and bits above the row field are don't-care, so rows wrap
  assign unused_addr = ^addr_a;

  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      bank_sel[p] = addr_a[p][2 +: BW];
      row_sel[p]  = addr_a[p][2+BW +: RW];
    end
    for (int b = 0; b < NUM_BANKS; b++)
      for (int p = 0; p < NUM_PORTS; p++)
        bank_hit[b][p] = i_rst_n & i_req[p] & (bank_sel[p] == BW'(b));
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    mem_bank_arb_bank #(
      .NUM_PORTS(NUM_PORTS), .BANK_DEPTH(BANK_DEPTH), .PW(PW), .RW(RW)
    ) u_bank (
      .i_clk  (i_clk),
      .i_rst_n(i_rst_n),
      .hit    (bank_hit[b]),
      .we     (i_we),
      .row    (row_sel),
      .wstrb  (wstrb_a),
      .wdata  (wdata_a),
      .gnt    (bank_gnt[b]),
      .rdata  (bank_rdata[b])
    );
  end

  // a port addresses exactly one bank, so OR-ing per-bank grants is safe
  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++)
      for (int b = 0; b < NUM_BANKS; b++)
        gnt_t[p][b] = bank_gnt[b][p];
    for (int p = 0; p < NUM_PORTS; p++)
      o_gnt[p] = |gnt_t[p];
  end

  assign denied  = CW'($countones(i_req & ~o_gnt));
  assign cnt_sum = {1'b0, cnt_q} + 33'(denied);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n)
      cnt_q <= '0;
    else
      cnt_q <= cnt_sum[32] ? '1 : cnt_sum[31:0];
  end
  assign o_conflict_cnt = i_rst_n ? cnt_q : '0;

  // flush kills reads granted this cycle and everything already in flight
  assign vld_in = o_gnt & ~i_we & {NUM_PORTS{~i_flush}};

  always_ff @(posedge i_clk) begin
    if (!i_rst_n)
      vld_pipe <= '0;
    else
      vld_pipe <= {vld_pipe[1] & {NUM_PORTS{~i_flush}}, vld_in};
  end

  always_ff @(posedge i_clk) begin
    bsel_q <= bank_sel;
    d2_q   <= d1;
  end

  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++)
      d1[p] = bank_rdata[bsel_q[p]];
  end

  assign d_out    = (RD_LAT == 2) ? d2_q : d1;
  assign o_rvalid = ((RD_LAT == 2) ? vld_pipe[2] : vld_pipe[1]) & {NUM_PORTS{i_rst_n}};

  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++)
      rdata_a[p] = o_rvalid[p] ? d_out[p] : 32'h0;
  end
endmodule

// File: doc/mem_bank_arb.md
MEM_BANK_ARB -- requirements
Module: mem_bank_arb

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 4, meaning the number of requester ports; port 0 is the config port.
REQ-002 SHALL have parameter NUM_BANKS, default 8, meaning the number of word-interleaved SRAM banks; it is a power of two, 2..16.
REQ-003 SHALL have parameter BANK_DEPTH, default 1024, meaning words per bank; it is a power of two.
REQ-004 SHALL have parameter RD_LAT, default 2, meaning read latency from grant to rvalid; legal values are 1 or 2.
REQ-005 SHALL have port i_clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port i_rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-007 SHALL have port i_flush, input, 1 bit: discards all in-flight read responses.
REQ-008 SHALL have port i_req, input, NUM_PORTS bits: per-port request.
REQ-009 SHALL have port i_we, input, NUM_PORTS bits: per-port write enable (1=write, 0=read).
REQ-010 SHALL have port i_addr, input, NUM_PORTS*32 bits: per-port byte address; port p occupies [32p+:32].
REQ-011 SHALL have port i_wstrb, input, NUM_PORTS*4 bits: per-port byte strobes.
REQ-012 SHALL have port i_wdata, input, NUM_PORTS*32 bits: per-port write data.
REQ-013 SHALL have port o_gnt, output, NUM_PORTS bits: per-port grant, combinational in the request cycle.
REQ-014 SHALL have port o_rvalid, output, NUM_PORTS bits: per-port read-data valid.
REQ-015 SHALL have port o_rdata, output, NUM_PORTS*32 bits: per-port read data.
REQ-016 SHALL have port o_conflict_cnt, output, 32 bits: saturating count of denied request-cycles.

Function
REQ-017 SHALL decode the bank as addr[2 +: log2(NUM_BANKS)] and the row as the next log2(BANK_DEPTH) bits; higher address bits SHALL be ignored, so rows wrap.
REQ-018 SHALL grant at most one port per bank per cycle; ports targeting different banks SHALL be granted in the same cycle.
REQ-019 SHALL give port 0 strict priority on every bank it targets.
REQ-020 SHALL arbitrate ports 1..NUM_PORTS-1 per bank round-robin: a per-bank pointer SHALL advance to one past the granted port, wrapping to 1 after NUM_PORTS-1; a port-0 grant SHALL leave the pointer unchanged.
REQ-021 SHALL hold requests valid until granted; o_gnt[p] SHALL be 0 whenever i_req[p]=0.
REQ-022 SHALL, on a granted write, update only the bytes selected by wstrb at the end of the grant cycle; wstrb=0 SHALL be granted with no change to memory.
REQ-023 SHALL, on a granted read, assert o_rvalid[p] for exactly one cycle RD_LAT cycles after grant, with o_rdata[p] holding the word; o_rdata SHALL be 0 when o_rvalid is 0.
REQ-024 SHALL sustain one read per cycle per port; back-to-back reads SHALL return in grant order.
REQ-025 SHALL, for a read and a write to the same bank/row granted on consecutive cycles (write first), return the written data to the read.
REQ-026 SHALL, when i_flush=1, clear the whole rvalid pipeline that cycle; reads granted in the flush cycle SHALL also be discarded; grants and writes SHALL be unaffected.
REQ-027 SHALL increment o_conflict_cnt by the number of ports with i_req=1 and o_gnt=0 in the cycle, saturating at 0xFFFFFFFF.

Reset
REQ-028 SHALL, while i_rst_n=0, drive o_gnt=0, o_rvalid=0, o_rdata=0 and o_conflict_cnt=0, set all round-robin pointers to 1, and perform no memory writes.
REQ-029 SHALL discard reads in flight when reset asserts; no rvalid SHALL appear for them after release.
REQ-030 SHALL NOT initialise memory contents on reset.

Verification
REQ-031 SHALL pass this scenario: port 1 writes 0xDEADBEEF to 0x10 with wstrb 0xF, then reads 0x10 (RD_LAT=2) -> o_rvalid[1] 2 cycles after the read grant, data 0xDEADBEEF.
REQ-032 SHALL pass this scenario: ports 1, 2 and 3 hold reads to bank 0 for 6 cycles -> grants in order 1,2,3,1,2,3; o_conflict_cnt=12.
REQ-033 SHALL pass this scenario: port 0 and port 2 both request bank 3 -> port 0 granted, port 2 granted the next cycle; a port-1 read to bank 4 in the same cycle is granted concurrently.
REQ-034 SHALL pass this scenario: port 1 writes 0x11223344 to 0x20, then a write with wstrb 0x2 and data 0xAABBCCDD -> a read returns 0x1122CC44.
REQ-035 SHALL pass this scenario: port 1 reads, then i_flush is asserted 1 cycle later -> no o_rvalid[1]; a read issued after the flush returns normally.
REQ-036 SHALL pass this scenario: reset asserted with two reads in flight -> all outputs 0, no rvalid after release, and the next arbitration in bank 0 favours port 1.
